// File: rtl/uart_rx_if.sv
// Byte output handshake of the UART receiver.
// The receiver drives data/valid; the consumer drives ready.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// Bit-serial UART receiver: start, 8 data bits MSB first, stop.
// Bytes land in a one-entry valid/ready buffer; errors pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic      CLK,
  input  logic      RESETN,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      overrun
);

  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HLAST = CW'((H > 0) ? H - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          done;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx) begin
          cnt_d = '0;
          // With H=0 the start sample is this very edge.
          if (H == 0) begin
            state_d = DATA;
            idx_d   = 3'd7;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        if (cnt_q == HLAST) begin
          cnt_d = '0;
          if (rx) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = 3'd7;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx;
          if (idx_q == 3'd0) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A byte arriving while the consumer drains still fits.
    if (done) begin
      if (!valid_q || bus.ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed vectors, corner sequences,
// and random line traffic against a frame-level model.
module tb_uart_rx;

  logic clk = 1'b0;
  logic RESETN = 1'b0;
  logic rx1 = 1'b1;
  logic rx4 = 1'b1;
  logic rdy1 = 1'b0;
  logic rdy4 = 1'b0;
  logic ferr1, ovr1, ferr4, ovr4;

  int ntot = 0;
  int npass = 0;

  always #5 clk = ~clk;

  uart_rx_if if1 ();
  uart_rx_if if4 ();
  assign if1.ready = rdy1;
  assign if4.ready = rdy4;

  uart_rx #(.CLKS_PER_BIT(1)) u1 (
    .CLK       (clk),
    .RESETN    (RESETN),
    .rx        (rx1),
    .bus       (if1),
    .frame_err (ferr1),
    .overrun   (ovr1)
  );

  uart_rx #(.CLKS_PER_BIT(4)) u4 (
    .CLK       (clk),
    .RESETN    (RESETN),
    .rx        (rx4),
    .bus       (if4),
    .frame_err (ferr4),
    .overrun   (ovr4)
  );

  // Event monitor for the 1-clock/bit receiver and u4 errors.
  int cyc = 0;
  int nferr1 = 0, novr1 = 0, nferr4 = 0, novr4 = 0;
  logic pv1 = 1'b0;
  logic [7:0] vq_data[$];
  int vq_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    nferr1 += int'(ferr1);
    novr1  += int'(ovr1);
    nferr4 += int'(ferr4);
    novr4  += int'(ovr4);
    if (if1.valid && !pv1) begin
      vq_data.push_back(if1.data);
      vq_cyc.push_back(cyc);
    end
    pv1 = if1.valid;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic send1(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rx1 = (k == 0) ? 1'b0 : (k == 9) ? stop : b[8-k];
    end
  endtask

  task automatic drain1();
    rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       ex_valid;
    logic [7:0] ex_data;
    logic       ex_ferr;
  } vec_t;

  // Frame-level reference: scan the whole line waveform.
  logic       w[$];
  logic       r[$];
  logic       m_dn[4096];
  logic       m_fe[4096];
  logic [7:0] m_dv[4096];

  task automatic rand_run(input int cpb, input int nf);
    int h, pos, s, st, n, sel;
    logic [7:0] b, ed;
    logic ev, eov;
    logic [10:0] act;
    w.delete();
    r.delete();
    h = (cpb - 1) / 2;
    repeat (4) w.push_back(1'b1);
    for (int f = 0; f < nf; f++) begin
      sel = $urandom_range(0, 9);
      repeat ($urandom_range(0, 3)) w.push_back(1'b1);
      if (sel == 0) begin
        w.push_back(1'b0);
        w.push_back(1'b1);
      end else begin
        b = 8'($urandom);
        for (int k = 0; k < 10; k++)
          repeat (cpb)
            w.push_back((k == 0) ? 1'b0 :
                        (k == 9) ? (sel != 1) : b[8-k]);
        if (sel == 1) begin
          repeat ($urandom_range(0, 5)) w.push_back(1'b0);
          w.push_back(1'b1);
        end
      end
    end
    repeat (12 * cpb + 4) w.push_back(1'b1);
    n = w.size();
    for (int i = 0; i < n; i++) begin
      r.push_back($urandom_range(0, 3) == 0);
      m_dn[i] = 1'b0;
      m_fe[i] = 1'b0;
      m_dv[i] = 8'h00;
    end
    pos = 0;
    while (pos < n) begin
      if (w[pos]) begin
        pos++;
      end else begin
        s  = pos + h;
        st = s + 9 * cpb;
        if (st >= n) break;
        if (w[s]) begin
          pos = s + 1;
        end else begin
          b = 8'h00;
          for (int k = 1; k <= 8; k++)
            b = {b[6:0], w[s + k * cpb]};
          pos = st + 1;
          if (w[st]) begin
            m_dn[st] = 1'b1;
            m_dv[st] = b;
          end else begin
            m_fe[st] = 1'b1;
            while (pos < n && !w[pos]) pos++;
            pos++;
          end
        end
      end
    end
    RESETN = 1'b0;
    rx1 = 1'b1; rx4 = 1'b1;
    rdy1 = 1'b0; rdy4 = 1'b0;
    @(negedge clk);
    RESETN = 1'b1;
    ev = 1'b0;
    ed = 8'h00;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        eov = 1'b0;
        if (m_dn[i-1]) begin
          if (!ev || r[i-1]) begin
            ev = 1'b1;
            ed = m_dv[i-1];
          end else begin
            eov = 1'b1;
          end
        end else if (ev && r[i-1]) begin
          ev = 1'b0;
        end
        act = (cpb == 1) ?
              {if1.valid, if1.data, ferr1, ovr1} :
              {if4.valid, if4.data, ferr4, ovr4};
        chk($sformatf("rand cpb%0d cyc%0d", cpb, i - 1),
            32'(act), 32'({ev, ed, m_fe[i-1], eov}));
      end
      if (i < n) begin
        if (cpb == 1) begin
          rx1 = w[i]; rdy1 = r[i];
        end else begin
          rx4 = w[i]; rdy4 = r[i];
        end
      end
    end
    rx1 = 1'b1; rx4 = 1'b1;
    rdy1 = 1'b0; rdy4 = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int b0, f0, o0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h55, 1'b0, 1'b0, 8'h00, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset u1", 32'({if1.valid, if1.data, ferr1, ovr1}), 0);
    chk("reset u4", 32'({if4.valid, if4.data, ferr4, ovr4}), 0);
    RESETN = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      send1(vecs[i].b, vecs[i].stop);
      chk($sformatf("vec%0d early", i), 32'(if1.valid), 0);
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), 32'(if1.valid),
          32'(vecs[i].ex_valid));
      if (vecs[i].ex_valid)
        chk($sformatf("vec%0d data", i), 32'(if1.data),
            32'(vecs[i].ex_data));
      chk($sformatf("vec%0d ferr", i), 32'(ferr1),
          32'(vecs[i].ex_ferr));
      rx1 = 1'b1;
      repeat (2) @(negedge clk);
      drain1();
      chk($sformatf("vec%0d drained", i), 32'(if1.valid), 0);
    end

    // Back-to-back frames with ready held.
    b0 = vq_data.size();
    o0 = novr1;
    rdy1 = 1'b1;
    send1(8'h3C, 1'b1);
    send1(8'hC3, 1'b1);
    repeat (3) @(negedge clk);
    rdy1 = 1'b0;
    chk("b2b count", 32'(vq_data.size() - b0), 2);
    if (vq_data.size() - b0 == 2) begin
      chk("b2b data0", 32'(vq_data[b0]), 32'h3C);
      chk("b2b data1", 32'(vq_data[b0+1]), 32'hC3);
      chk("b2b gap", 32'(vq_cyc[b0+1] - vq_cyc[b0]), 10);
    end
    chk("b2b ovr", 32'(novr1 - o0), 0);

    // Overrun: second byte dropped.
    o0 = novr1;
    send1(8'h11, 1'b1);
    send1(8'h22, 1'b1);
    @(negedge clk);
    chk("ovr pulse", 32'(ovr1), 1);
    repeat (2) @(negedge clk);
    chk("ovr once", 32'(novr1 - o0), 1);
    chk("ovr keep", 32'({if1.valid, if1.data}), 32'h111);
    drain1();
    chk("ovr drain", 32'(if1.valid), 0);

    // Framing error followed by a break.
    b0 = vq_data.size();
    f0 = nferr1;
    send1(8'h55, 1'b0);
    @(negedge clk);
    chk("ferr pulse", 32'(ferr1), 1);
    repeat (20) @(negedge clk);
    rx1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("ferr once", 32'(nferr1 - f0), 1);
    chk("ferr novalid", 32'(vq_data.size() - b0), 0);
    send1(8'h0F, 1'b1);
    @(negedge clk);
    chk("after ferr", 32'({if1.valid, if1.data}), 32'h10F);
    drain1();

    // False start then full frame at 4 clocks/bit.
    f0 = nferr4;
    o0 = novr4;
    @(negedge clk);
    rx4 = 1'b0;
    @(negedge clk);
    rx4 = 1'b1;
    repeat (8) @(negedge clk);
    chk("false start", 32'(if4.valid), 0);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 37) chk("cpb4 early", 32'(if4.valid), 0);
      if (j == 38)
        chk("cpb4 byte", 32'({if4.valid, if4.data}), 32'h181);
      rx4 = (j < 4) ? 1'b0 : (j >= 36) ? 1'b1 :
            (((8'h81 >> (7 - (j / 4 - 1))) & 8'h01) != 0);
    end
    repeat (4) @(negedge clk);
    chk("cpb4 flags", 32'((nferr4 - f0) + (novr4 - o0)), 0);

    // Reset in the middle of a frame.
    send1(8'h77, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rx1 = (k == 0) ? 1'b0 : ((8'hA6 >> (8 - k)) & 8'h01) != 0;
    end
    @(negedge clk);
    #2 RESETN = 1'b0;
    #1 chk("rst async", 32'({if1.valid, if1.data, ferr1, ovr1}), 0);
    @(negedge clk);
    rx1 = 1'b1;
    RESETN = 1'b1;
    @(negedge clk);
    send1(8'hFE, 1'b1);
    @(negedge clk);
    chk("after rst", 32'({if1.valid, if1.data}), 32'h1FE);
    drain1();

    rand_run(1, 30);
    rand_run(4, 25);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive side of the team's bit-serial UART link; the peer of the existing uart_tx.
- Deserialises a frame: one start bit (0), 8 data bits MSB first, one stop bit (1).
- Presents each received byte on a one-entry valid/ready output buffer.
- Reports framing and overrun errors as single-cycle pulses.
- Default bit timing is one bit per CLK, which matches uart_tx exactly.

Parameters:
- CLKS_PER_BIT, 1: CLK cycles per bit. Must be >= 1.

Ports:
- CLK  input  1  system clock; all logic is rising-edge.
- RESETN  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; synchronous to CLK, idles at 1, no synchroniser.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data when valid&&ready at a rising edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: completed byte dropped because the buffer was full.

Behaviour:
- Reset (RESETN=0, asynchronous):
  - state=IDLE; data=8'h00; valid=0; frame_err=0; overrun=0; all counters 0.
  - Reset mid-frame abandons the frame silently.
- Timing:
  - H=(CLKS_PER_BIT-1)/2, integer division.
  - Let e0 be the first rising edge in IDLE at which rx==0.
  - Bit k (0=start, 1..8=data, 9=stop) is sampled at edge e0 + k*CLKS_PER_BIT + H.
  - With CLKS_PER_BIT=1 the samples are e0, e0+1 .. e0+8, e0+9.
- States:
  - IDLE: rx==0 -> START, clock-phase counter cleared. With H=0 the start sample is e0 itself, so go directly to DATA.
  - START: at the start sample, rx==1 is a false start -> IDLE with no flags; rx==0 -> DATA with bit index=7.
  - DATA: at each sample, shift_reg[index] <= rx and index decrements. At index 0 -> STOP. Bit 1 lands in shift_reg[7] (MSB first).
  - STOP, sample rx==1: byte complete -> IDLE.
  - STOP, sample rx==0: frame_err=1 for one cycle, byte discarded, valid/data unchanged -> WAIT_HIGH.
  - WAIT_HIGH: stay until an edge with rx==1 -> IDLE. A held-low line (break) never produces a spurious frame.
- Output buffer, evaluated at the byte-complete edge:
  - valid==0, or (valid && ready): data <= shift_reg, valid <= 1, overrun stays 0.
  - valid && !ready: byte dropped; data/valid retain the old byte; overrun=1 for one cycle.
  - On any other edge, valid && ready -> valid <= 0 and data is held.
- Latency: valid is visible after edge e0 + 9*CLKS_PER_BIT + H. For CLKS_PER_BIT=1 that is 10 cycles from the start-bit edge.
- Back-to-back frames: a new start is accepted on the first IDLE edge after the stop sample. This matches uart_tx sending frames with no idle gap.
- Error pulses may coincide with valid; they never coincide with each other.

Test Plan:
- Single byte, CLKS_PER_BIT=1: drive 0, then bits of 8'hA5 MSB first, then 1 -> valid rises after edge e0+9, data=8'hA5, no flags. With ready=1 for one cycle, valid drops next edge.
- Back-to-back: frames 8'h3C then 8'hC3 with no idle gap, ready held 1 -> two valid pulses 10 cycles apart with correct data, overrun never asserted.
- Overrun: receive 8'h11 with ready=0, then a full 8'h22 frame -> overrun pulses once at the second stop edge; data stays 8'h11 and valid=1. Asserting ready=1 then clears valid.
- Framing error: frame 8'h55 with stop bit 0, then rx held 0 for 20 cycles, then 1 -> frame_err pulses once, valid stays 0, no further frames. The next proper frame 8'h0F is received correctly.
- False start, CLKS_PER_BIT=4 (H=1): rx low for 1 cycle only -> returns to IDLE with no flags. A full frame 8'h81 at 4 clocks/bit then yields data=8'h81 after edge e0+37.
- Reset mid-frame: RESETN=0 after the 4th data bit -> outputs 0 immediately. After release with rx=1, a new frame 8'hFE is received correctly.
